// File: rtl/pulse_train_decoder.sv
// Receive-side decoder for the idle-high, active-low pulse-train link.
// Counts low pulses per burst and reports the count once the line has idled for GAP_CYCLES samples.
module pulse_train_decoder #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned GAP_W      = 4
) (
  input  logic             outclk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [GAP_W-1:0] GapEnd = GAP_W'(GAP_CYCLES);

  state_e           r_state, w_state_next;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_ovf, w_ovf_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;
  logic [CNT_W-1:0] r_count_out, w_count_out_next;
  logic             r_overflow, w_overflow_next;
  logic             r_count_valid, w_count_valid_next;
  logic             w_fe;
  logic [GAP_W-1:0] w_gap_inc;

  // Synchronizer and history flops reset high so reset release never looks like a falling edge.
  always_ff @(posedge outclk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= pulse_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_fe      = r_s3 & ~r_s2;
  assign w_gap_inc = r_gap + GAP_W'(1);

  always_ff @(posedge outclk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_gap         <= '0;
      r_count_out   <= '0;
      r_overflow    <= 1'b0;
      r_count_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_ovf         <= w_ovf_next;
      r_gap         <= w_gap_next;
      r_count_out   <= w_count_out_next;
      r_overflow    <= w_overflow_next;
      r_count_valid <= w_count_valid_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_ovf_next         = r_ovf;
    w_gap_next         = r_gap;
    w_count_out_next   = r_count_out;
    w_overflow_next    = r_overflow;
    w_count_valid_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_fe) begin
          w_state_next = StCount;
          w_cnt_next   = CNT_W'(1);
          w_ovf_next   = 1'b0;
          w_gap_next   = '0;
        end
      end
      StCount: begin
        if (w_fe) begin
          // Saturate rather than wrap; overflow remembers that pulses were lost.
          if (r_cnt == CntMax) begin
            w_ovf_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
          w_gap_next = '0;
        end else if (!r_s2) begin
          w_gap_next = '0;
        end else if (w_gap_inc == GapEnd) begin
          w_state_next       = StIdle;
          w_gap_next         = '0;
          w_count_out_next   = r_cnt;
          w_overflow_next    = r_ovf;
          w_count_valid_next = 1'b1;
        end else begin
          w_gap_next = w_gap_inc;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign count_out   = r_count_out;
  assign overflow    = r_overflow;
  assign count_valid = r_count_valid;
  assign busy        = (r_state == StCount);

endmodule

// File: doc/pulse_train_decoder.md
Name: pulse_train_decoder

Overview:
Receive-side decoder for the single-wire pulse-train link driven by the pulse_counter generator. It samples the idle-high, active-low pulse line in the outclk domain and counts low pulses within a burst. When the line has stayed idle for a programmed gap, it reports the burst length with a one-cycle valid strobe. It feeds the scoring/control logic with decoded counts.

Parameters:
CNT_W, 4, width of the pulse count; maximum reportable count is 2^CNT_W-1.
GAP_CYCLES, 8, number of consecutive high synchronized samples that ends a burst; legal range 2..2^GAP_W-1.
GAP_W, 4, width of the gap timer.

Ports:
outclk  input  1  sampling/system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
pulse_in  input  1  raw pulse line, asynchronous to outclk; idles high; each low period is one pulse.
count_out  output  CNT_W  pulse count of the last completed burst; held until the next report.
count_valid  output  1  one-cycle strobe; count_out and overflow are valid in this cycle.
overflow  output  1  set with count_valid when the burst had more than 2^CNT_W-1 pulses.
busy  output  1  high while a burst is being counted (state COUNT).

Behaviour:
- Reset, asserted asynchronously:
  - count_out=0, count_valid=0, overflow=0, busy=0.
  - Synchronizer flops and the edge-history flop = 1, so no pulse is detected after reset.
  - Internal count=0, gap timer=0, state=IDLE.
- Synchronization: 2-flop synchronizer (s1, s2) plus a history flop s3.
  - Falling edge event fe = s3 & ~s2.
  - Only s2, s3 and fe are used downstream. Raw-to-s2 latency is 2 cycles.
- Minimum pulse: a low or high phase must last at least 2 outclk periods for guaranteed detection. Shorter glitches may be missed; they must never be double-counted.
- State IDLE (busy=0):
  - fe -> COUNT, cnt=1, ovf=0, gap=0.
  - Otherwise stay in IDLE.
- State COUNT (busy=1):
  - fe: if cnt==2^CNT_W-1, hold cnt and set ovf=1; else cnt=cnt+1. In both cases gap=0.
  - s2==0 without fe (line low): gap=0, hold cnt.
  - s2==1: gap=gap+1.
  - When gap+1==GAP_CYCLES: next cycle count_out=cnt, overflow=ovf, count_valid=1; state -> IDLE, gap=0.
- count_valid is high for exactly 1 cycle per burst.
- count_out and overflow update only on a report and hold their values otherwise.
- Report latency: count_valid rises GAP_CYCLES+3 outclk cycles after the last raw rising edge of the burst (±1 cycle for synchronizer phase).
- Simultaneous events:
  - fe and gap expiry cannot coincide, because expiry requires s2==1.
  - A fe in the same cycle count_valid is asserted is the first pulse of a new burst: the state returns to COUNT with cnt=1 and the report still completes.
- Line stuck low: remains in COUNT with busy=1 and no report until the line returns high for GAP_CYCLES samples.
- Reset mid-burst: the burst is discarded, no count_valid is produced, and outputs return to reset values.
- Saturation: counts are capped at 2^CNT_W-1 with overflow=1; no wrap-around.
- ovf is cleared at the start of each burst.

Test Plan:
- Reset release with pulse_in held high for 50 cycles -> count_valid never asserts; busy=0, count_out=0, overflow=0.
- Three low pulses, each 3 cycles low / 3 high, then idle high -> one count_valid with count_out=3, overflow=0. Strobe is 1 cycle wide, GAP_CYCLES+3 (±1) cycles after the last rising edge. busy is high from about 2 cycles after the first fall until the report.
- 17 pulses with CNT_W=4 -> count_out=15, overflow=1. A following burst of 2 pulses -> count_out=2, overflow=0.
- Two bursts of 2 pulses separated by a 6-cycle high gap (GAP_CYCLES=8) -> a single report with count_out=4. The same pattern with a 12-cycle gap -> two reports, each with count_out=2.
- Assert rst after the 2nd of 4 pulses, then release it and idle -> no count_valid for the aborted burst. A fresh 1-pulse burst -> count_out=1.
- pulse_in held low for 40 cycles then high -> busy stays high throughout, then exactly one report with count_out=1. A 1-cycle-low glitch must not produce count_out>1.
